// File: rtl/cs_window_filter.sv
// rtl/cs_window_filter.sv - sliding-window approximate-average filter
// Stage 1 holds the window and running sum; stage 2 registers the selected result.
module cs_window_filter #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 9,
  parameter  int SHIFT  = 3,
  localparam int SUM_W  = DATA_W + $clog2(DEPTH + 1),
  localparam int Y_W    = DATA_W + $clog2(2 * DEPTH) - SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  input  logic              mode,
  input  logic              flush,
  output logic [Y_W-1:0]    y,
  output logic              y_valid,
  output logic              window_full
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FULL_W = DATA_W + $clog2(2 * DEPTH);

  logic [DATA_W-1:0] w [DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt;
  logic              acc_d;

  logic [SUM_W-1:0]  avg;
  logic [DATA_W-1:0] x_appr;
  logic [FULL_W-1:0] appr_full;
  logic [Y_W-1:0]    result;
  logic              cnt_full;

  assign cnt_full    = (cnt == CNT_W'(DEPTH));
  assign window_full = cnt_full;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) w[i] <= '0;
      sum   <= '0;
      cnt   <= '0;
      acc_d <= 1'b0;
    end else if (in_valid) begin
      w[0] <= x;
      for (int i = 1; i < DEPTH; i++) w[i] <= w[i-1];
      // The window sum is bounded by DEPTH * max sample, so SUM_W never wraps.
      sum   <= sum - SUM_W'(w[DEPTH-1]) + SUM_W'(x);
      if (!cnt_full) cnt <= cnt + CNT_W'(1);
      acc_d <= 1'b1;
    end else begin
      acc_d <= 1'b0;
    end
  end

  always_comb begin
    avg    = sum / SUM_W'(DEPTH);
    x_appr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((SUM_W'(w[i]) <= avg) && (w[i] >= x_appr)) x_appr = w[i];
    end
    appr_full = FULL_W'(sum) + FULL_W'(DEPTH) * FULL_W'(x_appr);
    result    = mode ? Y_W'(avg) : Y_W'(appr_full >> SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (flush) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= acc_d && cnt_full;
      if (acc_d && cnt_full) y <= result;
    end
  end

endmodule

// File: tb/tb_cs_window_filter.sv
// tb/tb_cs_window_filter.sv - scoreboard bench for cs_window_filter
// A queue-based window model predicts results; a negedge monitor compares them.
module tb_cs_window_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] x = '0;
  logic       mode = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] y;
  logic       y_valid;
  logic       window_full;

  logic       b_in_valid = 1'b0;
  logic [7:0] b_x = '0;
  logic       b_mode = 1'b0;
  logic       b_flush = 1'b0;
  logic [8:0] b_y;
  logic       b_y_valid;
  logic       b_window_full;

  int total = 0;
  int bad = 0;

  int  exp_q[$];
  int  win[$];
  int  pend_win[$];
  bit  pend = 1'b0;
  bit  exp_full = 1'b0;
  int  last_y = 0;

  always #5 clk = ~clk;

  cs_window_filter #(.DATA_W(8), .DEPTH(9), .SHIFT(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .mode(mode),
    .flush(flush), .y(y), .y_valid(y_valid), .window_full(window_full)
  );

  cs_window_filter #(.DATA_W(8), .DEPTH(4), .SHIFT(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .x(b_x), .mode(b_mode),
    .flush(b_flush), .y(b_y), .y_valid(b_y_valid), .window_full(b_window_full)
  );

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int calc(int q[$], int depth, int shift, bit md);
    int s = 0;
    int a;
    int xa = 0;
    foreach (q[i]) s += q[i];
    a = s / depth;
    foreach (q[i]) if (q[i] <= a && q[i] > xa) xa = q[i];
    return md ? a : (s + depth * xa) >> shift;
  endfunction

  // Reference model: window of accepted samples since reset/flush, newest first.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        win.delete();
        exp_q.delete();
        pend = 1'b0;
        last_y = 0;
        exp_full = 1'b0;
      end else begin
        if (pend && !flush) exp_q.push_back(calc(pend_win, 9, 3, mode));
        pend = 1'b0;
        if (flush) win.delete();
        else if (in_valid) begin
          win.push_front(int'(x));
          if (win.size() > 9) void'(win.pop_back());
          if (win.size() == 9) begin
            pend = 1'b1;
            pend_win = win;
          end
        end
        exp_full = (win.size() == 9);
      end
    end
  end

  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (y_valid || exp_q.size() > 0) begin
        if (exp_q.size() == 0) chk("unexpected_y_valid", int'(y_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("y_valid", int'(y_valid), 1);
          chk("y", int'(y), e);
          last_y = e;
        end
      end else begin
        chk("y_hold", int'(y), last_y);
      end
      chk("window_full", int'(window_full), int'(exp_full));
    end
  end

  task automatic drive(bit v, int xv, bit md, bit fl);
    @(negedge clk);
    in_valid = v;
    x = 8'(xv);
    mode = md;
    flush = fl;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic b_send(int xv, bit md);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_x = 8'(xv);
    b_mode = md;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_y", int'(y), 0);
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_window_full", int'(window_full), 0);
    reset = 1'b0;

    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 10 * i, 1'b0, 1'b0);
      if (i == 9) chk("warmup_not_full", int'(window_full), 0);
    end
    idle();
    chk("full_before_valid", int'(window_full), 1);
    chk("no_early_valid", int'(y_valid), 0);
    idle();
    chk("warmup_vld", int'(y_valid), 1);
    chk("warmup_y", int'(y), 112);

    drive(1'b1, 100, 1'b0, 1'b0);
    idle();
    idle();
    chk("slide_y", int'(y), 135);
    drive(1'b1, 110, 1'b1, 1'b0);
    idle();
    idle();
    chk("slide_mode1_y", int'(y), 70);

    for (int i = 0; i < 9; i++) drive(1'b1, 255, 1'b0, 1'b0);
    idle();
    idle();
    chk("sat_y", int'(y), 573);
    drive(1'b1, 255, 1'b1, 1'b0);
    idle();
    idle();
    chk("sat_mode1_y", int'(y), 255);

    drive(1'b0, 0, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom_range(255), 1'b0, 1'b0);
      idle();
    end
    drive(1'b1, 77, 1'b0, 1'b1);
    idle();
    chk("flush_window_full", int'(window_full), 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom_range(255), 1'b0, 1'b0);
      idle();
      chk("post_flush_no_valid", int'(y_valid), 0);
    end
    drive(1'b1, $urandom_range(255), 1'b0, 1'b0);
    idle();
    idle();
    chk("post_flush_first_valid", int'(y_valid), 1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9) < 7, $urandom_range(255), 1'($urandom_range(1)),
            $urandom_range(49) == 0);
    end

    for (int i = 0; i < 9; i++) drive(1'b1, $urandom_range(255), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_y", int'(y), 0);
    chk("midreset_y_valid", int'(y_valid), 0);
    chk("midreset_window_full", int'(window_full), 0);
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) drive(1'b1, 10 * i, 1'b0, 1'b0);
    idle();
    idle();
    chk("refill_y", int'(y), 112);

    repeat (3) idle();
    chk("drain_empty", exp_q.size(), 0);

    b_send(1, 1'b0);
    b_send(2, 1'b0);
    chk("b_warm_vld", int'(b_y_valid), 0);
    b_send(3, 1'b0);
    chk("b_warm_vld", int'(b_y_valid), 0);
    b_send(10, 1'b0);
    chk("b_warm_vld", int'(b_y_valid), 0);
    chk("b_warm_full", int'(b_window_full), 0);
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_full", int'(b_window_full), 1);
    chk("b_early_vld", int'(b_y_valid), 0);
    @(negedge clk);
    chk("b_vld", int'(b_y_valid), 1);
    chk("b_y", int'(b_y), 7);
    b_send(20, 1'b1);
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_mode1_y", int'(b_y), 8);
    b_send(4, 1'b0);
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_mode0_y", int'(b_y), 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
